// File: rtl/aib_axi_follower_wr_rx.sv
// Follower-side AIB receive block for the AXI write path: decodes 80-bit PHY words into
// AW/W entries, buffers each channel in its own FIFO and returns one credit per entry drained.

module aib_axi_follower_wr_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             ovf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full | do_pop);
    assign ovf_o   = push_i & full & ~do_pop;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the count decides which entries are live and
    // the head is forced to zero while empty, so stale contents never reach the outputs.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign valid_o = ~empty;
    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
endmodule

module aib_axi_follower_wr_rx #(
    parameter int AW_DEPTH  = 4,
    parameter int W_DEPTH   = 8,
    parameter int ADDRWIDTH = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr,
    input  logic                  rx_online,
    input  logic [79:0]           rx_phy0,
    output logic [ID_W-1:0]       user_awid,
    output logic [ADDRWIDTH-1:0]  user_awaddr,
    output logic [7:0]            user_awlen,
    output logic [2:0]            user_awsize,
    output logic [1:0]            user_awburst,
    output logic                  user_awvalid,
    input  logic                  user_awready,
    output logic [DATA_W-1:0]     user_wdata,
    output logic [DATA_W/8-1:0]   user_wstrb,
    output logic                  user_wlast,
    output logic                  user_wvalid,
    input  logic                  user_wready,
    output logic                  aw_credit_ret,
    output logic                  w_credit_ret,
    output logic                  ovf_err,
    output logic                  bad_type_err
);
    localparam int AW_PW  = 49;  // {id[4], addr[32], len[8], size[3], burst[2]}
    localparam int W_PW   = 73;  // {last[1], strb[8], data[64]}
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] TYPE_AW  = 2'b01;
    localparam logic [1:0] TYPE_W   = 2'b10;
    localparam logic [1:0] TYPE_RSV = 2'b11;

    logic              accept;
    logic [1:0]        word_type;
    logic              aw_push, w_push, bad_word;
    logic [AW_PW-1:0]  aw_wdata, aw_head;
    logic [W_PW-1:0]   w_wdata, w_head;
    logic              aw_pop, w_pop, aw_ovf, w_ovf;
    logic              unused_bits;

    logic aw_credit_q, aw_credit_d;
    logic w_credit_q, w_credit_d;
    logic ovf_err_q, ovf_err_d;
    logic bad_type_err_q, bad_type_err_d;

    assign accept    = rx_online & rx_phy0[79];
    assign word_type = rx_phy0[78:77];
    assign aw_push   = accept & (word_type == TYPE_AW);
    assign w_push    = accept & (word_type == TYPE_W);
    assign bad_word  = accept & (word_type == TYPE_RSV);

    assign aw_wdata = {rx_phy0[48:45], rx_phy0[31:0], rx_phy0[44:37], rx_phy0[36:34], rx_phy0[33:32]};
    assign w_wdata  = {rx_phy0[72], rx_phy0[71:64], rx_phy0[63:0]};
    assign unused_bits = ^rx_phy0[76:73];

    assign aw_pop = user_awvalid & user_awready;
    assign w_pop  = user_wvalid & user_wready;

    aib_axi_follower_wr_rx_fifo #(.WIDTH(AW_PW), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk_i   (clk_wr),
        .rst_i   (rst_wr),
        .push_i  (aw_push),
        .wdata_i (aw_wdata),
        .pop_i   (user_awready),
        .rdata_o (aw_head),
        .valid_o (user_awvalid),
        .ovf_o   (aw_ovf)
    );

    aib_axi_follower_wr_rx_fifo #(.WIDTH(W_PW), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk_i   (clk_wr),
        .rst_i   (rst_wr),
        .push_i  (w_push),
        .wdata_i (w_wdata),
        .pop_i   (user_wready),
        .rdata_o (w_head),
        .valid_o (user_wvalid),
        .ovf_o   (w_ovf)
    );

    assign user_awid    = ID_W'(aw_head[48:45]);
    assign user_awaddr  = ADDRWIDTH'(aw_head[44:13]);
    assign user_awlen   = aw_head[12:5];
    assign user_awsize  = aw_head[4:2];
    assign user_awburst = aw_head[1:0];

    assign user_wlast = w_head[72];
    assign user_wstrb = STRB_W'(w_head[71:64]);
    assign user_wdata = DATA_W'(w_head[63:0]);

    // One credit pulse per pop, registered so back-to-back pops give back-to-back pulses.
    always_comb begin
        aw_credit_d    = aw_pop;
        w_credit_d     = w_pop;
        ovf_err_d      = ovf_err_q | aw_ovf | w_ovf;
        bad_type_err_d = bad_type_err_q | bad_word;
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            aw_credit_q    <= 1'b0;
            w_credit_q     <= 1'b0;
            ovf_err_q      <= 1'b0;
            bad_type_err_q <= 1'b0;
        end else begin
            aw_credit_q    <= aw_credit_d;
            w_credit_q     <= w_credit_d;
            ovf_err_q      <= ovf_err_d;
            bad_type_err_q <= bad_type_err_d;
        end
    end

    assign aw_credit_ret = aw_credit_q;
    assign w_credit_ret  = w_credit_q;
    assign ovf_err       = ovf_err_q;
    assign bad_type_err  = bad_type_err_q;
endmodule

// File: tb/tb_aib_axi_follower_wr_rx.sv
// Self-checking bench: directed scenarios plus random traffic, compared each cycle
// against a queue-based reference model of the follower receive path.

module tb_aib_axi_follower_wr_rx;
    localparam int AW_DEPTH = 4;
    localparam int W_DEPTH  = 8;

    logic        clk_wr = 1'b0;
    logic        rst_wr;
    logic        rx_online;
    logic [79:0] rx_phy0;
    logic [3:0]  user_awid;
    logic [31:0] user_awaddr;
    logic [7:0]  user_awlen;
    logic [2:0]  user_awsize;
    logic [1:0]  user_awburst;
    logic        user_awvalid;
    logic        user_awready;
    logic [63:0] user_wdata;
    logic [7:0]  user_wstrb;
    logic        user_wlast;
    logic        user_wvalid;
    logic        user_wready;
    logic        aw_credit_ret;
    logic        w_credit_ret;
    logic        ovf_err;
    logic        bad_type_err;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per channel plus expected credit/error flags.
    logic [48:0] m_aw[$];
    logic [72:0] m_w[$];
    bit m_awc, m_wc, m_ovf, m_bad;

    always #5 clk_wr = ~clk_wr;

    aib_axi_follower_wr_rx #(
        .AW_DEPTH(AW_DEPTH), .W_DEPTH(W_DEPTH), .ADDRWIDTH(32), .DATA_W(64), .ID_W(4)
    ) dut (
        .clk_wr       (clk_wr),
        .rst_wr       (rst_wr),
        .rx_online    (rx_online),
        .rx_phy0      (rx_phy0),
        .user_awid    (user_awid),
        .user_awaddr  (user_awaddr),
        .user_awlen   (user_awlen),
        .user_awsize  (user_awsize),
        .user_awburst (user_awburst),
        .user_awvalid (user_awvalid),
        .user_awready (user_awready),
        .user_wdata   (user_wdata),
        .user_wstrb   (user_wstrb),
        .user_wlast   (user_wlast),
        .user_wvalid  (user_wvalid),
        .user_wready  (user_wready),
        .aw_credit_ret(aw_credit_ret),
        .w_credit_ret (w_credit_ret),
        .ovf_err      (ovf_err),
        .bad_type_err (bad_type_err)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [79:0] aw_word(input logic [3:0] id, input logic [31:0] addr,
                                            input logic [7:0] len, input logic [2:0] size,
                                            input logic [1:0] burst);
        logic [79:0] w;
        w = '0;
        w[79] = 1'b1;
        w[78:77] = 2'b01;
        w[31:0] = addr;
        w[33:32] = burst;
        w[36:34] = size;
        w[44:37] = len;
        w[48:45] = id;
        return w;
    endfunction

    function automatic logic [79:0] w_word(input logic [63:0] data, input logic [7:0] strb,
                                           input logic last);
        logic [79:0] w;
        w = '0;
        w[79] = 1'b1;
        w[78:77] = 2'b10;
        w[63:0] = data;
        w[71:64] = strb;
        w[72] = last;
        return w;
    endfunction

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic step(input bit rst, input bit online, input logic [79:0] word,
                        input bit awr, input bit wr);
        logic [48:0] aw_exp;
        logic [72:0] w_exp;
        bit aw_pop, w_pop;
        rst_wr = rst;
        rx_online = online;
        rx_phy0 = word;
        user_awready = awr;
        user_wready = wr;
        #1;
        aw_exp = (m_aw.size() != 0) ? m_aw[0] : '0;
        w_exp  = (m_w.size() != 0) ? m_w[0] : '0;
        check("awvalid", user_awvalid, m_aw.size() != 0);
        check("aw_head", {user_awid, user_awaddr, user_awlen, user_awsize, user_awburst}, aw_exp);
        check("wvalid", user_wvalid, m_w.size() != 0);
        check("w_head", {user_wlast, user_wstrb, user_wdata}, w_exp);
        check("aw_credit_ret", aw_credit_ret, m_awc);
        check("w_credit_ret", w_credit_ret, m_wc);
        check("ovf_err", ovf_err, m_ovf);
        check("bad_type_err", bad_type_err, m_bad);

        if (rst) begin
            m_aw.delete();
            m_w.delete();
            m_awc = 0; m_wc = 0; m_ovf = 0; m_bad = 0;
        end else begin
            aw_pop = (m_aw.size() != 0) && awr;
            w_pop  = (m_w.size() != 0) && wr;
            if (aw_pop) void'(m_aw.pop_front());
            if (w_pop) void'(m_w.pop_front());
            if (online && word[79]) begin
                case (word[78:77])
                    2'b01: begin
                        if (m_aw.size() < AW_DEPTH)
                            m_aw.push_back({word[48:45], word[31:0], word[44:37], word[36:34], word[33:32]});
                        else
                            m_ovf = 1;
                    end
                    2'b10: begin
                        if (m_w.size() < W_DEPTH)
                            m_w.push_back({word[72], word[71:64], word[63:0]});
                        else
                            m_ovf = 1;
                    end
                    2'b11: m_bad = 1;
                    default: ;
                endcase
            end
            m_awc = aw_pop;
            m_wc = w_pop;
        end
        @(posedge clk_wr);
        @(negedge clk_wr);
    endtask

    task automatic idle(input int n, input bit awr, input bit wr);
        for (int i = 0; i < n; i++) step(0, 1, '0, awr, wr);
    endtask

    initial begin
        logic [95:0] r;
        logic [79:0] word;
        int w_credits;

        rst_wr = 1'b1;
        rx_online = 1'b0;
        rx_phy0 = '0;
        user_awready = 1'b0;
        user_wready = 1'b0;
        repeat (2) @(posedge clk_wr);
        @(negedge clk_wr);

        // Reset state is checked by the first compare of step.
        idle(1, 0, 0);

        // Single AW with awready high: valid next cycle, credit the cycle after.
        step(0, 1, aw_word(4'd5, 32'h1000_0040, 8'd3, 3'd3, 2'b01), 1, 1);
        check("single_aw_addr", user_awaddr, 32'h1000_0040);
        idle(3, 1, 1);

        // W burst with wready toggling; count credit pulses independently of the model.
        w_credits = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, w_word(64'hA0 + 64'(i), 8'hFF, i == 3), (i % 2) == 0, (i % 2) == 0);
            w_credits += int'(w_credit_ret);
        end
        for (int i = 4; i < 14; i++) begin
            step(0, 1, '0, 1, (i % 2) == 0);
            w_credits += int'(w_credit_ret);
        end
        check("w_burst_credits", w_credits, 4);

        // Fill the AW FIFO with awready low, then overflow on the 5th word.
        for (int i = 0; i < 5; i++)
            step(0, 1, aw_word(4'(i), 32'h2000_0000 + 32'(i * 64), 8'(i), 3'd2, 2'b01), 0, 1);
        check("fill_ovf_sticky", ovf_err, 1'b1);
        idle(2, 0, 1);
        idle(7, 1, 1);

        // Full FIFO with simultaneous push and pop: no overflow.
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 1, aw_word(4'(i + 8), 32'h3000_0000 + 32'(i), 8'd0, 3'd0, 2'b00), 0, 1);
        step(0, 1, aw_word(4'hF, 32'h3000_00FF, 8'd7, 3'd1, 2'b10), 1, 1);
        check("full_push_pop_no_ovf", ovf_err, 1'b0);
        idle(7, 1, 1);

        // rx_online gating, then reserved type.
        for (int i = 0; i < 3; i++)
            step(0, 0, aw_word(4'd1, 32'h4000_0000, 8'd1, 3'd1, 2'b01), 1, 1);
        check("offline_no_valid", user_awvalid, 1'b0);
        step(0, 1, 80'h1 << 79 | 80'h3 << 77 | 80'h1234, 1, 1);
        check("bad_type_set", bad_type_err, 1'b1);
        idle(2, 1, 1);

        // Reset with three W entries buffered, then a single W word.
        for (int i = 0; i < 3; i++) step(0, 1, w_word(64'hB0 + 64'(i), 8'h0F, 1'b0), 1, 0);
        step(1, 1, '0, 1, 0);
        check("post_reset_wvalid", user_wvalid, 1'b0);
        step(0, 1, w_word(64'hC0, 8'h3C, 1'b1), 1, 1);
        check("post_reset_w_data", user_wdata, 64'hC0);
        idle(3, 1, 1);

        // Random traffic with random backpressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            word = r[79:0];
            if ($urandom_range(0, 7) == 0) word[78:77] = 2'b11;
            else if (word[78:77] == 2'b11) word[78:77] = 2'b01;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, word,
                 $urandom_range(0, 3) == 0 ? 1'b0 : ((i / 200) % 2 == 0),
                 $urandom_range(0, 2) != 0);
        end
        idle(12, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
